// File: rtl/alu_pkg.sv
// Shared ALU types: opcodes, loader FSM states and the loader's state-sequencing helper.
package alu_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        OR  = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        SHOW    = 2'b11
    } loader_state_t;

    // ENTER walks the loader round-robin: LOAD_A -> LOAD_B -> LOAD_OP -> SHOW -> LOAD_A.
    function automatic loader_state_t nextLoaderState(input loader_state_t s);
        loader_state_t n;
        case (s)
            LOAD_A:  n = LOAD_B;
            LOAD_B:  n = LOAD_OP;
            LOAD_OP: n = SHOW;
            default: n = LOAD_A;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/alu_operand_loader_button_debouncer.sv
// Active-low pushbutton conditioner: 2-FF synchronizer, stable-sample counter, press-edge detect.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          levelPrev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any synchronized sample equal to the accepted level restarts the run of differing samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            level_d = sync_q[1];
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Reset assumes "pressed" so a button held through reset never produces a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b00;
            level_q     <= 1'b0;
            levelPrev_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync_q      <= {sync_q[0], btn_n};
            level_q     <= level_d;
            levelPrev_q <= level_q;
            cnt_q       <= cnt_d;
        end
    end

    assign press = levelPrev_q & ~level_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Sequences operand A, operand B and opcode into registered ALU inputs using debounced ENTER/CLEAR.
// Optional FLAG_LATCH_EN adds alu_flags/flags_q to capture ALU flags on the issue cycle.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int N               = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw,
    input  logic [1:0]   op_sw,
    input  logic         btn_enter_n,
    input  logic         btn_clear_n,
`ifdef FLAG_LATCH_EN
    input  logic [3:0]   alu_flags,
    output logic [3:0]   flags_q,
`endif
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [1:0]   operator,
    output logic         issue,
    output logic         result_vld,
    output logic [1:0]   stage
);

    logic [1:0]    rstSync_q;
    logic          rstInt_n;
    logic          enterPress, clearPress;
    logic [N-1:0]  sw1_q, sw2_q;
    logic [1:0]    op1_q, op2_q;
    loader_state_t state_q, state_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d;
    opcode_t       op_q, op_d;
    logic          issue_q, issue_d;
    logic          resultVld_q, resultVld_d;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstSync_q <= 2'b00;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
        end
    end

    assign rstInt_n = rstSync_q[1];

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uEnter (
        .clk   (clk),
        .rst_n (rstInt_n),
        .btn_n (btn_enter_n),
        .press (enterPress)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uClear (
        .clk   (clk),
        .rst_n (rstInt_n),
        .btn_n (btn_clear_n),
        .press (clearPress)
    );

    always_ff @(posedge clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            sw1_q <= '0;
            sw2_q <= '0;
            op1_q <= 2'b00;
            op2_q <= 2'b00;
        end else begin
            sw1_q <= sw;
            sw2_q <= sw1_q;
            op1_q <= op_sw;
            op2_q <= op1_q;
        end
    end

    always_ff @(posedge clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            state_q <= LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    // CLEAR takes priority and swallows a coincident ENTER.
    always_comb begin
        state_d = state_q;
        if (clearPress) begin
            state_d = LOAD_A;
        end else if (enterPress) begin
            state_d = nextLoaderState(state_q);
        end
    end

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        issue_d     = 1'b0;
        resultVld_d = (state_d == SHOW);
        if (clearPress) begin
            a_d  = '0;
            b_d  = '0;
            op_d = ADD;
        end else if (enterPress) begin
            case (state_q)
                LOAD_A:  a_d = sw2_q;
                LOAD_B:  b_d = sw2_q;
                LOAD_OP: begin
                    op_d    = opcode_t'(op2_q);
                    issue_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= ADD;
            issue_q     <= 1'b0;
            resultVld_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            issue_q     <= issue_d;
            resultVld_q <= resultVld_d;
        end
    end

`ifdef FLAG_LATCH_EN
    // The ALU's flags for the new operation are valid during the issue cycle itself.
    always_ff @(posedge clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            flags_q <= 4'b0000;
        end else if (clearPress) begin
            flags_q <= 4'b0000;
        end else if (issue_q) begin
            flags_q <= alu_flags;
        end
    end
`endif

    assign a          = a_q;
    assign b          = b_q;
    assign operator   = op_q;
    assign issue      = issue_q;
    assign result_vld = resultVld_q;
    assign stage      = state_q;

endmodule
